// File: rtl/vx_onehot_stream_arb_pkg.sv
// Shared helpers for the one-hot round-robin stream arbiter: index sizing,
// one-hot to index conversion and the priority pointer reset value.
package vx_onehot_stream_arb_pkg;

   localparam int MAX_N      = 64;
   localparam int RESET_PRIO = 0;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int onehot_to_idx(input logic [MAX_N-1:0] oh);
      int idx;
      idx = 0;
      for (int k = 0; k < MAX_N; k++) begin
         if (oh[k]) idx = k;
      end
      return idx;
   endfunction

endpackage

// File: rtl/vx_onehot_stream_arb_mux.sv
// One-hot payload steer: ORs together the payload slices whose select bit is set.
module vx_onehot_stream_arb_mux #(
   parameter int N     = 4,
   parameter int DATAW = 32
) (
   input  logic [N*DATAW-1:0] data_in,
   input  logic [N-1:0]       sel_in,
   output logic [DATAW-1:0]   data_out
);

   always_comb begin
      data_out = '0;
      for (int k = 0; k < N; k++) begin
         if (sel_in[k]) data_out = data_out | data_in[k*DATAW +: DATAW];
      end
   end

endmodule

// File: rtl/vx_onehot_stream_arb.sv
// N-input round-robin stream arbiter with one-hot grant, payload steer through
// the one-hot mux, and either a one-entry output register or a combinational path.
module vx_onehot_stream_arb
   import vx_onehot_stream_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int DATAW   = 32,
   parameter int OUT_BUF = 1,
   parameter int LOCK    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       valid_in,
   input  logic [N*DATAW-1:0] data_in,
   output logic [N-1:0]       ready_in,
   output logic               valid_out,
   output logic [DATAW-1:0]   data_out,
   output logic [N-1:0]       sel_out,
   input  logic               ready_out
);

   localparam int PW       = idx_width(N);
   localparam bit USE_LOCK = (OUT_BUF == 0) && (LOCK != 0);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic             lock_q, lock_d;
   logic [N-1:0]     lgrant_q, lgrant_d;
   logic [N-1:0]     rr_grant, grant;
   logic [MAX_N-1:0] grant_ext;
   logic             stage_rdy, fire_in;
   logic [DATAW-1:0] mux_data;

   // Circular scan for the first requester at or after the priority pointer.
   always_comb begin
      logic          found;
      logic [PW-1:0] jj;
      found    = 1'b0;
      jj       = '0;
      rr_grant = '0;
      for (int k = 0; k < N; k++) begin
         jj = PW'((int'(ptr_q) + k) % N);
         if (valid_in[jj] && !found) begin
            rr_grant[jj] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign grant    = (USE_LOCK && lock_q) ? lgrant_q : rr_grant;
   assign ready_in = reset ? '0 : (grant & {N{stage_rdy}});
   assign fire_in  = |(valid_in & ready_in);

   always_comb begin
      grant_ext         = '0;
      grant_ext[N-1:0]  = grant;
      ptr_d             = ptr_q;
      if (fire_in) ptr_d = PW'((onehot_to_idx(grant_ext) + 1) % N);
      lock_d            = USE_LOCK ? (valid_out & ~ready_out) : 1'b0;
      lgrant_d          = USE_LOCK ? grant : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q    <= PW'(RESET_PRIO);
         lock_q   <= 1'b0;
         lgrant_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         lock_q   <= lock_d;
         lgrant_q <= lgrant_d;
      end
   end

   vx_onehot_stream_arb_mux #(
      .N     (N),
      .DATAW (DATAW)
   ) u_mux (
      .data_in  (data_in),
      .sel_in   (grant),
      .data_out (mux_data)
   );

   if (OUT_BUF != 0) begin : g_buf
      logic             vout_q, vout_d;
      logic [DATAW-1:0] dout_q, dout_d;
      logic [N-1:0]     sel_q, sel_d;

      // Fill wins over drain so a beat can leave and enter in the same cycle.
      always_comb begin
         vout_d = vout_q;
         dout_d = dout_q;
         sel_d  = sel_q;
         if (fire_in) begin
            vout_d = 1'b1;
            dout_d = mux_data;
            sel_d  = grant;
         end else if (ready_out) begin
            vout_d = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            vout_q <= 1'b0;
            dout_q <= '0;
            sel_q  <= '0;
         end else begin
            vout_q <= vout_d;
            dout_q <= dout_d;
            sel_q  <= sel_d;
         end
      end

      assign stage_rdy = ~vout_q | ready_out;
      assign valid_out = vout_q;
      assign data_out  = dout_q;
      assign sel_out   = sel_q;
   end else begin : g_comb
      assign stage_rdy = ready_out;
      assign valid_out = |valid_in;
      assign data_out  = mux_data;
      assign sel_out   = grant;
   end

   a_grant_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_ready_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(ready_in));

   if (OUT_BUF != 0) begin : g_chk_buf
      a_buf_stall: assert property (@(posedge clk) disable iff (reset)
         (valid_out && !ready_out) |=> (valid_out && $stable(data_out) && $stable(sel_out)));
   end

   if (USE_LOCK) begin : g_chk_lock
      a_lock_stall: assert property (@(posedge clk) disable iff (reset)
         (valid_out && !ready_out) |=> (valid_out && $stable(sel_out)));
      // Upstream must keep the locked request up until it is accepted.
      a_lock_hold: assert property (@(posedge clk) disable iff (reset)
         lock_q |-> (|(valid_in & lgrant_q)));
   end

endmodule
